// File: rtl/oam_dma_m_if.sv
// Byte-wide memory bus shared by the CPU register port and the DMA initiator port.
// The master drives address/data/strobe; the slave returns read data combinationally.
interface mem_if;
    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    // Handshake: a write happens on any rising clock edge where write_enable=1
    // and there is no ready or back-pressure. read_out is valid within the cycle
    // that addr_select is presented.
    modport master (output addr_select, write_value, write_enable, input read_out);
    modport slave  (input addr_select, write_value, write_enable, output read_out);
endinterface

// File: rtl/oam_dma_m.sv
// OAM DMA engine. A write to REG_ADDR starts (or restarts) a NUM_BYTES copy into OAM_BASE.
// Each byte takes three cycles: read, wait, write. Define OAM_DMA_START_DELAY_EN to add a 4-cycle idle lead-in.
module oam_dma_m #(
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] OAM_BASE  = 16'hFE00,
    parameter int          NUM_BYTES = 160
) (
    input  logic       clk,
    input  logic       rst,
    mem_if.slave       reg_if,
    mem_if.master      dma_req,
    output logic       dma_active,
    output logic       dma_done,
    output logic [2:0] dbg_state_o
);
    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RD, S_WT, S_WR} state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    state_t      state_q;
    logic [7:0]  src_q;
    logic [7:0]  idx_q;
    logic [7:0]  data_q;
    logic [15:0] addr_q;
    logic        we_q;
    logic        active_q;
    logic        done_q;
    logic [1:0]  dly_q;
    logic        start;

    // Echo region E0-FF aliases down to C0-DF.
    function automatic logic [7:0] src_hi(input logic [7:0] v);
        return (v > 8'hDF) ? (v & 8'hDF) : v;
    endfunction

    assign start          = reg_if.write_enable && (reg_if.addr_select == REG_ADDR);
    assign reg_if.read_out = (reg_if.addr_select == REG_ADDR) ? src_q : 8'hFF;

    assign dma_req.addr_select  = addr_q;
    assign dma_req.write_value  = data_q;
    assign dma_req.write_enable = we_q;
    assign dma_active           = active_q;
    assign dma_done             = done_q;
    assign dbg_state_o          = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_q    <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            addr_q   <= 16'hFFFF;
            we_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            dly_q    <= 2'd0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                src_q    <= reg_if.write_value;
                idx_q    <= 8'h00;
                data_q   <= 8'h00;
                we_q     <= 1'b0;
                active_q <= 1'b1;
                dly_q    <= 2'd0;
`ifdef OAM_DMA_START_DELAY_EN
                state_q  <= S_DELAY;
                addr_q   <= 16'hFFFF;
`else
                state_q  <= S_RD;
                addr_q   <= {src_hi(reg_if.write_value), 8'h00};
`endif
            end else begin
                case (state_q)
                    S_DELAY: begin
                        if (dly_q == 2'd3) begin
                            state_q <= S_RD;
                            addr_q  <= {src_hi(src_q), idx_q};
                        end else begin
                            dly_q <= dly_q + 2'd1;
                        end
                    end
                    S_RD: state_q <= S_WT;
                    S_WT: begin
                        data_q  <= dma_req.read_out;
                        we_q    <= 1'b1;
                        addr_q  <= OAM_BASE + {8'h00, idx_q};
                        state_q <= S_WR;
                    end
                    S_WR: begin
                        we_q   <= 1'b0;
                        data_q <= 8'h00;
                        if (idx_q == LAST_IDX) begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                            addr_q   <= 16'hFFFF;
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            addr_q  <= {src_hi(src_q), idx_q + 8'd1};
                            state_q <= S_RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oam_dma_m.sv
// Randomized self-checking bench for oam_dma_m against a per-cycle transfer-schedule model.
// Honours OAM_DMA_START_DELAY_EN the same way the design does.
module tb_oam_dma_m;
  `ifdef OAM_DMA_START_DELAY_EN
  localparam int D = 4;
  `else
  localparam int D = 0;
  `endif
  localparam int NB = 160;
  localparam int TOTAL = D + 3 * NB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_if reg_bus ();
  mem_if dma_bus ();
  logic       act;
  logic       done;
  logic [2:0] dbg_state;

  oam_dma_m dut (
    .clk        (clk),
    .rst        (rst),
    .reg_if     (reg_bus),
    .dma_req    (dma_bus),
    .dma_active (act),
    .dma_done   (done),
    .dbg_state_o(dbg_state)
  );

  // memory environment: A000-BFFF is unmapped and reads FF
  logic [7:0] mem [0:65535];
  assign dma_bus.read_out = (dma_bus.addr_select[15:13] == 3'b101) ? 8'hFF : mem[dma_bus.addr_select];
  always @(posedge clk) if (dma_bus.write_enable) mem[dma_bus.addr_select] = dma_bus.write_value;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return (a[15:13] == 3'b101) ? 8'hFF : mem[a];
  endfunction

  function automatic logic [7:0] hi_of(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int act_cnt = 0;

  task automatic check(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // reference model: where in the transfer schedule we are
  logic       m_active = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_src = 8'h00;
  logic       m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_src = 8'h00; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (reg_bus.write_enable && reg_bus.addr_select == 16'hFF46) begin
        m_src = reg_bus.write_value; m_active = 1'b1; m_cnt = 0;
      end else if (m_active) begin
        if (m_cnt == TOTAL - 1) begin
          m_active = 1'b0; m_done = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [15:0] e_addr;
    logic        e_we, e_act, e_done, wv_chk;
    logic [7:0]  e_wv, e_rd, b8;
    int e, b, ph;
    wv_chk = 1'b1; e_wv = 8'h00; e_we = 1'b0; e_addr = 16'hFFFF; e_act = 1'b0; e_done = 1'b0;
    if (rst || !m_active) begin
      e_done = rst ? 1'b0 : m_done;
    end else begin
      e_act = 1'b1;
      e = m_cnt - D;
      if (e >= 0) begin
        b = e / 3; ph = e % 3; b8 = b[7:0];
        if (ph < 2) begin
          e_addr = {hi_of(m_src), b8}; wv_chk = 1'b0;
        end else begin
          e_addr = 16'hFE00 + {8'h00, b8}; e_we = 1'b1;
          e_wv = src_byte({hi_of(m_src), b8});
        end
      end
    end
    if (reg_bus.addr_select == 16'hFF46) e_rd = rst ? 8'h00 : m_src;
    else e_rd = 8'hFF;
    check("dma_addr", dma_bus.addr_select, e_addr);
    check("dma_we", {15'd0, dma_bus.write_enable}, {15'd0, e_we});
    if (wv_chk) check("dma_wv", {8'd0, dma_bus.write_value}, {8'd0, e_wv});
    check("dma_active", {15'd0, act}, {15'd0, e_act});
    check("dma_done", {15'd0, done}, {15'd0, e_done});
    check("reg_read", {8'd0, reg_bus.read_out}, {8'd0, e_rd});
    if (done) done_cnt++;
    if (act) act_cnt++;
  end

  // driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] v);
    reg_bus.addr_select = a; reg_bus.write_value = v; reg_bus.write_enable = 1'b1;
    @(posedge clk); #1;
    reg_bus.write_enable = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no dma_done expected within 3000 cycles");
    end
  endtask

  task automatic oam_vs(input string nm, input logic [7:0] hi);
    int bad = 0;
    for (int i = 0; i < NB; i++) begin
      logic [15:0] o, s;
      o = 16'hFE00 + 16'(i); s = {hi, 8'(i)};
      if (mem[o] !== src_byte(s)) bad++;
    end
    check(nm, 16'(bad), 16'd0);
  endtask

  logic [7:0] snap [0:79];
  int cyc, d0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
    rst = 1'b1;
    reg_bus.addr_select = 16'hFF46; reg_bus.write_value = 8'h00; reg_bus.write_enable = 1'b0;
    step(2);
    check("rst_addr", dma_bus.addr_select, 16'hFFFF);
    check("rst_active", {15'd0, act}, 16'd0);
    check("rst_src", {8'd0, reg_bus.read_out}, 16'h0000);
    rst = 1'b0;
    step(2);

    // C1: exact byte-0 schedule, done/active timing, copy result
    act_cnt = 0;
    wr_reg(16'hFF46, 8'hC1);
    step(D);
    check("c1_rd_addr", dma_bus.addr_select, 16'hC100);
    check("c1_rd_we", {15'd0, dma_bus.write_enable}, 16'd0);
    step(1);
    check("c1_wt_addr", dma_bus.addr_select, 16'hC100);
    step(1);
    check("c1_wr_addr", dma_bus.addr_select, 16'hFE00);
    check("c1_wr_we", {15'd0, dma_bus.write_enable}, 16'd1);
    wait_done(cyc);
    cyc = cyc + D + 2;
    check("c1_done_cycle", 16'(cyc), 16'(481 + D));
    check("c1_active_cycles", 16'(act_cnt), 16'(480 + D));
    oam_vs("c1_oam", 8'hC1);
    step(3);

    // E2: echo alias and register readback mid-transfer
    wr_reg(16'hFF46, 8'hE2);
    step(D);
    check("e2_src_addr", dma_bus.addr_select, 16'hC200);
    step(100);
    check("e2_readback", {8'd0, reg_bus.read_out}, 16'h00E2);
    wait_done(cyc);
    oam_vs("e2_oam", 8'hC2);
    step(3);

    // restart at byte 50
    d0 = done_cnt;
    wr_reg(16'hFF46, 8'hC0);
    step(D + 150);
    wr_reg(16'hFF46, 8'hD0);
    step(D);
    check("restart_addr", dma_bus.addr_select, 16'hD000);
    wait_done(cyc);
    step(5);
    check("restart_one_done", 16'(done_cnt - d0), 16'd1);
    oam_vs("restart_oam", 8'hD0);

    // restart on the final WR suppresses that done
    d0 = done_cnt;
    wr_reg(16'hFF46, 8'hC3);
    step(TOTAL - 1);
    check("final_wr_we", {15'd0, dma_bus.write_enable}, 16'd1);
    wr_reg(16'hFF46, 8'hC4);
    check("final_restart_nodone", {15'd0, done}, 16'd0);
    wait_done(cyc);
    step(5);
    check("final_restart_one_done", 16'(done_cnt - d0), 16'd1);
    oam_vs("final_restart_oam", 8'hC4);

    // reset during byte 80's WT
    for (int i = 0; i < 80; i++) snap[i] = mem[16'hFE50 + 16'(i)];
    wr_reg(16'hFF46, 8'hC8);
    step(D + 241);
    rst = 1'b1;
    #1;
    check("abort_addr", dma_bus.addr_select, 16'hFFFF);
    check("abort_we", {15'd0, dma_bus.write_enable}, 16'd0);
    check("abort_active", {15'd0, act}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(20);
    check("abort_stays_idle", {15'd0, act}, 16'd0);
    begin
      int bad = 0;
      for (int i = 0; i < 80; i++) if (mem[16'hFE50 + 16'(i)] !== snap[i]) bad++;
      check("abort_oam_kept", 16'(bad), 16'd0);
    end
    check("abort_byte79", {8'd0, mem[16'hFE4F]}, {8'd0, src_byte(16'hC84F)});

    // write to a neighbouring address does nothing
    wr_reg(16'hFF47, 8'h55);
    check("ff47_read", {8'd0, reg_bus.read_out}, 16'h00FF);
    step(5);
    check("ff47_no_xfer", {15'd0, act}, 16'd0);
    reg_bus.addr_select = 16'hFF46;
    #1;
    check("ff47_src_kept", {8'd0, reg_bus.read_out}, 16'h0000);

    // randomized transfers with restarts and stray register traffic
    for (int t = 0; t < 6; t++) begin
      wr_reg(16'hFF46, 8'($urandom_range(0, 255)));
      for (int k = 0; k < 20; k++) begin
        reg_bus.addr_select = 16'hFF40 + 16'($urandom_range(0, 15));
        step($urandom_range(1, 20));
      end
      if ($urandom_range(0, 1) == 1) wr_reg(16'hFF46, 8'($urandom_range(0, 255)));
      wait_done(cyc);
      step($urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
